mmio_timer_tube: RTL and testbench
==================================

# mmio_timer_tube

Memory-mapped peripheral responder on the CPU data bus, decoding the MEM-stage bus signals (MemRead, MemWrite, address, write data) and returning read data in the same cycle. It contains:
- a 32-bit auto-reload timer with a sticky interrupt flag;
- a 4-digit hexadecimal 7-segment scan driver;
- an optional free-running system tick counter.

It sits beside DataMemory, and the CPU steers I/O-space accesses to it.

## Interface
Parameters:
- BASE_ADDR, 32'h4000_0000, base of the 32-byte peripheral window
- SCAN_DIV, 100000, clk cycles each digit is lit (≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemRead  in  1  bus read strobe
- MemWrite  in  1  bus write strobe
- Address  in  32  byte address; bits [1:0] ignored
- Write_data  in  32  write data
- Read_data  out  32  read data, combinational
- irq  out  1  timer interrupt, equals TCON[2]
- Tube_display  out  4  digit select, one-hot active-low, bit0 = rightmost digit
- Tube_segment  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

## Operation
Register map, as offsets from BASE_ADDR:
- 0x00 TH: reload value, R/W.
- 0x04 TL: counter, R/W.
- 0x08 TCON, R/W:
  - bit0: enable.
  - bit1: irq enable.
  - bit2: irq status, sticky.
  - Bits [31:3] read 0.
- 0x10 DIGITS, R/W: bits [15:0] are four hex nibbles, nibble0 shown on digit0. Bits [31:16] read 0.
- 0x14 SYSTICK, R/W: only with SYSTICK_EN.
- Any other offset in the window, or any address outside it: reads 0, writes ignored.

Bus:
- Hit = Address[31:5] == BASE_ADDR[31:5].
- Read_data = selected register when MemRead && hit, else 32'h0.
- A write takes effect on the rising clk edge when MemWrite && hit.

Timer, each clk while TCON[0]=1:
- If TL == 32'hFFFF_FFFF: TL <= TH, and TCON[2] <= 1 if TCON[1]=1.
- Otherwise TL <= TL + 1.
- While TCON[0]=0, TL holds.
- TCON[2] is cleared only by a bus write of 0 to bit2.

Tube scan:
- scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
- On the wrap, digit index idx advances 0→1→2→3→0.
- Tube_display = ~(4'b0001 << idx).
- Tube_segment = hex decode of DIGITS nibble[idx], with dp always 1. Decode: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- Both tube outputs are combinational from idx and DIGITS.

Simultaneous events:
- A bus write to TL, TH or TCON in the same cycle as a timer update: the bus write wins entirely, including the status bit.
- A write to TH does not affect the current count.

## Timing
Reset (reset=0, asynchronous) clears TH, TL, TCON, DIGITS, SYSTICK, scan_cnt and idx to 0. Resulting outputs:
- irq=0
- Tube_display=4'b1110
- Tube_segment=8'hC0
- Read_data=0 when no read is in progress

Latencies:
- Read: 0 cycles; Read_data is valid in the same cycle as MemRead.
- Write: visible to a read in the following cycle.
- irq: asserts the cycle after the wrap edge.
- DIGITS change: appears on Tube_segment the cycle after the write edge.

Reset asserted mid-count or mid-scan forces the reset values immediately. Counting resumes from 0 on the first clk edge after reset deasserts.

## Configuration
SYSTICK_EN:
- Defined: offset 0x14 holds a 32-bit counter that increments every clk and wraps from 32'hFFFF_FFFF to 0. A bus write loads Write_data and takes priority over the increment.
- Undefined: no counter is built; offset 0x14 reads 0 and writes are ignored.

## Test plan
- Reset: hold reset=0 → Tube_display=1110, Tube_segment=C0, irq=0; read TCON (0x4000_0008) → 0.
- Timer wrap:
  - Stimulus: write TH=FFFF_FFFD, TL=FFFF_FFFE, TCON=3.
  - Next-cycle read of TL → FFFF_FFFF.
  - Following cycle: TL → FFFF_FFFD, irq=1, TCON reads 7.
  - Write TCON=3 → irq=0.
- Write priority: TCON=1 and TL counting; write TL=0000_0010 → next-cycle read of TL returns 0000_0010, not the incremented value.
- Scan (SCAN_DIV=4):
  - Write DIGITS=0x1234.
  - Digit0 shows seg 99 for 4 cycles.
  - Then display=1101 with seg B0, then 1011 with A4, then 0111 with F9.
  - Then digit0 again.
- Decode:
  - MemRead with Address=0x4000_0020 → Read_data 0.
  - MemRead=0 with Address=0x4000_0004 → 0.
  - MemWrite to 0x4000_000C → no register changes.
- SYSTICK:
  - SYSTICK_EN defined: write FFFF_FFFF, then two cycles later read → 0000_0001.
  - SYSTICK_EN undefined: read → 0.

Source files
------------

// File: rtl/mmio_timer_tube.sv
// mmio_timer_tube: bus-mapped auto-reload timer, 4-digit hex 7-segment scanner and,
// when SYSTICK_EN is defined, a free-running tick counter at offset 0x14.
module mmio_timer_tube #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        irq,
    output logic [3:0]  Tube_display,
    output logic [7:0]  Tube_segment
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [7:0] HEX_SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    logic        hit;
    logic [2:0]  off;
    logic        wrTh, wrTl, wrTcon, wrDigits, wrap;
    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic [15:0] digits;
    logic [CW-1:0] scanCnt;
    logic [1:0]  idx;
    logic [3:0]  nibble;
    logic        unusedAddrBits;
    assign hit      = Address[31:5] == BASE_ADDR[31:5];
    assign off      = Address[4:2];
    assign wrTh     = MemWrite && hit && off == 3'd0;
    assign wrTl     = MemWrite && hit && off == 3'd1;
    assign wrTcon   = MemWrite && hit && off == 3'd2;
    assign wrDigits = MemWrite && hit && off == 3'd4;
    assign wrap     = tcon[0] && tl == 32'hFFFF_FFFF;
    assign unusedAddrBits = ^Address[1:0];
    // Bus writes take precedence over the timer's own update of the same register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wrTh) th <= Write_data;
            if (wrTl) tl <= Write_data;
            else if (wrap) tl <= th;
            else if (tcon[0]) tl <= tl + 32'd1;
            if (wrTcon) tcon <= Write_data[2:0];
            else if (wrap && tcon[1]) tcon[2] <= 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits  <= '0;
            scanCnt <= '0;
            idx     <= '0;
        end else begin
            if (wrDigits) digits <= Write_data[15:0];
            if (scanCnt == CW'(SCAN_DIV - 1)) begin
                scanCnt <= '0;
                idx     <= idx + 2'd1;
            end else begin
                scanCnt <= scanCnt + 1'b1;
            end
        end
    end
`ifdef SYSTICK_EN
    logic [31:0] sysTick;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sysTick <= '0;
        else sysTick <= (MemWrite && hit && off == 3'd5) ? Write_data : sysTick + 32'd1;
    end
`endif
    always_comb begin
        Read_data = '0;
        if (MemRead && hit)
            case (off)
                3'd0: Read_data = th;
                3'd1: Read_data = tl;
                3'd2: Read_data = {29'd0, tcon};
                3'd4: Read_data = {16'd0, digits};
`ifdef SYSTICK_EN
                3'd5: Read_data = sysTick;
`endif
                default: Read_data = '0;
            endcase
    end
    assign irq          = tcon[2];
    assign nibble       = digits[{idx, 2'b00} +: 4];
    assign Tube_display = ~(4'b0001 << idx);
    assign Tube_segment = HEX_SEG[nibble];
endmodule

// File: tb/tb_mmio_timer_tube.sv
// tb_mmio_timer_tube: table vectors, directed corner sequences and randomized traffic
// checked against a cycle-count based reference model of mmio_timer_tube.
module tb_mmio_timer_tube;
    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int SD = 4;
    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] Address = '0, Write_data = '0;
    logic [31:0] Read_data;
    logic        irq;
    logic [3:0]  Tube_display;
    logic [7:0]  Tube_segment;

    mmio_timer_tube #(.BASE_ADDR(BASE), .SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
        .irq(irq), .Tube_display(Tube_display), .Tube_segment(Tube_segment)
    );

    always #5 clk = ~clk;

    int nVec = 0, nMis = 0;
    logic [31:0] mTh, mTl, mSys;
    logic [2:0]  mTcon;
    logic [15:0] mDigits;
    int          mCyc;
    logic [31:0] rdSample;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mRead(input logic rd, input logic [31:0] a);
        if (!rd || a[31:5] != BASE[31:5]) return 32'h0;
        case (a[4:2])
            3'd0: return mTh;
            3'd1: return mTl;
            3'd2: return {29'd0, mTcon};
            3'd4: return {16'd0, mDigits};
`ifdef SYSTICK_EN
            3'd5: return mSys;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic mClear();
        mTh = 0; mTl = 0; mSys = 0; mTcon = 0; mDigits = 0; mCyc = 0;
    endtask

    // One bus cycle: drive at posedge+1, compare at negedge, advance model at posedge.
    task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] nTl, sh;
        logic [2:0]  nTcon;
        logic [3:0]  dExp;
        logic        w;
        int          pos;
        MemRead = rd; MemWrite = wr; Address = a; Write_data = wd;
        @(negedge clk);
        pos  = (mCyc / SD) % 4;
        dExp = ~(4'b0001 << pos);
        sh   = {16'd0, mDigits} >> (4 * pos);
        rdSample = Read_data;
        chk("rdata", Read_data, mRead(rd, a));
        chk("irq", irq, mTcon[2]);
        chk("display", Tube_display, dExp);
        chk("segment", Tube_segment, HEX[sh[3:0]]);
        @(posedge clk);
        w = wr && a[31:5] == BASE[31:5];
        nTl = mTl; nTcon = mTcon;
        if (mTcon[0]) begin
            if (mTl == 32'hFFFF_FFFF) begin
                nTl = mTh;
                if (mTcon[1]) nTcon[2] = 1'b1;
            end else nTl = mTl + 1;
        end
        if (w && a[4:2] == 3'd0) mTh = wd;
        if (w && a[4:2] == 3'd1) nTl = wd;
        if (w && a[4:2] == 3'd2) nTcon = wd[2:0];
        if (w && a[4:2] == 3'd4) mDigits = wd[15:0];
        mSys = (w && a[4:2] == 3'd5) ? wd : mSys + 1;
        mTl = nTl; mTcon = nTcon; mCyc++;
        #1;
    endtask

    task automatic peek(input string nm, input logic [31:0] a, input logic [31:0] exp);
        MemRead = 1'b1; MemWrite = 1'b0; Address = a;
        #1;
        chk(nm, Read_data, exp);
    endtask

    // Called at posedge+1; asserts reset mid-cycle and releases it so the next edge is cycle 1.
    task automatic doReset();
        MemRead = 1'b0; MemWrite = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rst_irq", irq, 1'b0);
        chk("rst_display", Tube_display, 4'b1110);
        chk("rst_segment", Tube_segment, 8'hC0);
        chk("rst_rdata", Read_data, 32'h0);
        mClear();
        repeat (2) @(posedge clk);
        #1;
        peek("rst_tcon", BASE + 32'h8, 32'h0);
        reset = 1'b1;
    endtask

    logic [3:0] dispTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] segTab  [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    initial begin
        mClear();
        repeat (2) @(posedge clk);
        #1;
        doReset();

        tbl.push_back('{1'b0, 1'b1, BASE + 32'h00, 32'hA5A5_0001, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h00, 32'h0,         32'hA5A5_0001});
        tbl.push_back('{1'b0, 1'b1, BASE + 32'h04, 32'h1234_5678, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h04, 32'h0,         32'h1234_5678});
        tbl.push_back('{1'b0, 1'b1, BASE + 32'h10, 32'hFFFF_ABCD, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h10, 32'h0,         32'h0000_ABCD});
        tbl.push_back('{1'b0, 1'b1, BASE + 32'h08, 32'hFFFF_FFFA, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h08, 32'h0,         32'h0000_0002});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h20, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 1'b0, BASE + 32'h04, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 1'b1, BASE + 32'h0C, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h0C, 32'h0,         32'h0});
        tbl.push_back('{1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h03, 32'h0,         32'hA5A5_0001});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h05, 32'h0,         32'h1234_5678});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h18, 32'h0,         32'h0});
        tbl.push_back('{1'b1, 1'b0, BASE + 32'h1C, 32'h0,         32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd);
            chk($sformatf("tbl%0d", i), rdSample, tbl[i].exp);
        end

        // Timer wrap with reload and sticky status.
        step(0, 1, BASE + 32'h00, 32'hFFFF_FFFD);
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
        step(0, 1, BASE + 32'h08, 32'h3);
        step(0, 0, 0, 0);
        peek("wrap_tl_max", BASE + 32'h04, 32'hFFFF_FFFF);
        chk("wrap_irq_pre", irq, 1'b0);
        step(0, 0, 0, 0);
        peek("wrap_tl_reload", BASE + 32'h04, 32'hFFFF_FFFD);
        peek("wrap_tcon", BASE + 32'h08, 32'h7);
        chk("wrap_irq", irq, 1'b1);
        step(0, 1, BASE + 32'h08, 32'h3);
        chk("irq_clear", irq, 1'b0);

        // Bus write beats the running increment.
        step(0, 1, BASE + 32'h04, 32'h0000_0010);
        peek("prio_tl", BASE + 32'h04, 32'h0000_0010);
        step(0, 0, 0, 0);
        peek("prio_tl_next", BASE + 32'h04, 32'h0000_0011);

        // TCON write on the wrap cycle suppresses the status set.
        step(0, 1, BASE + 32'h04, 32'hFFFF_FFFE);
        step(0, 0, 0, 0);
        step(0, 1, BASE + 32'h08, 32'h1);
        peek("coll_tcon", BASE + 32'h08, 32'h1);
        peek("coll_tl", BASE + 32'h04, 32'hFFFF_FFFD);
        chk("coll_irq", irq, 1'b0);
        step(0, 1, BASE + 32'h08, 32'h0);

        // Scan sequence from a fresh reset.
        doReset();
        step(0, 1, BASE + 32'h10, 32'h1234);
        for (int j = 1; j <= 17; j++) begin
            chk($sformatf("scan_disp%0d", j), Tube_display, dispTab[(j / 4) % 4]);
            chk($sformatf("scan_seg%0d", j), Tube_segment, segTab[(j / 4) % 4]);
            step(0, 0, 0, 0);
        end

        step(0, 1, BASE + 32'h14, 32'hFFFF_FFFF);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
`ifdef SYSTICK_EN
        peek("systick", BASE + 32'h14, 32'h0000_0001);
`else
        peek("systick", BASE + 32'h14, 32'h0);
`endif

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, wd;
            logic [2:0]  o;
            int r;
            r  = $urandom_range(0, 9);
            o  = 3'($urandom_range(0, 7));
            a  = (r == 9) ? $urandom : BASE | {27'd0, o, 2'b00} | 32'($urandom_range(0, 3));
            wd = $urandom;
            if (o == 3'd1 && $urandom_range(0, 2) == 0) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), r < 4, a, wd);
            if (k == 200) doReset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
